// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
// ----------------------
// Main controller for the multicycle RV32I core. Each instruction is sequenced
// through fetch, decode, execute, memory and writeback states. The controller
// drives aluop into alu_control, together with all datapath enables and mux
// selects. It stalls while memory is not ready. It traps into a sticky FAULT
// state on an illegal opcode, or when a memory access waits too long.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   op           instruction opcode (IR[6:0]), valid from DECODE onward
//   funct3       IR[14:12]
//   zero         ALU zero flag
//   mem_ready    memory completes the current access this cycle
//   aluop        to alu_control: 00 add, 01 sub/compare, 10 funct-decoded
//   funct7_valid gates the funct7 input of alu_control
//   pcwrite      PC register enable
//   irwrite      instruction/old-PC register enable
//   memwrite     memory write strobe
//   regwrite     register file write enable
//   adrsrc       memory address select: 0 PC, 1 ALU result
//   resultsrc    result select: 00 ALUOut, 01 Data, 10 ALUResult
//   alusrca      ALU A select: 00 PC, 01 OldPC, 10 rs1
//   alusrcb      ALU B select: 00 rs2, 01 imm, 10 constant 4
//   state        current state encoding, for debug
//   fault        00 none, 01 illegal opcode, 10 memory timeout
//
// Handshake: the memory has no valid/ready pair. In FETCH, MEMREAD and
// MEMWRITE the access is presented and held every cycle. A cycle with
// mem_ready = 1 completes the access and advances the state. A cycle with
// mem_ready = 0 keeps the state and counts as one wait cycle.
module multicycle_control_fsm #(
    parameter int WAIT_LIMIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [1:0] aluop,
    output logic       funct7_valid,
    output logic       pcwrite,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regwrite,
    output logic       adrsrc,
    output logic [1:0] resultsrc,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [3:0] state,
    output logic [1:0] fault
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECUTEI = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_FAULT    = 4'd11
    } state_t;

    localparam logic [7:0] LIMIT_M1 = 8'(WAIT_LIMIT - 1);

    state_t     state_q, state_d;
    logic [1:0] fault_q, fault_d;
    logic [7:0] wait_cnt;

    logic pcupdate, branch, irwrite_raw, memwrite_raw, regwrite_raw;
    logic wait_state, timeout;

    // Only the three memory-facing states can stall on mem_ready.
    assign wait_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                        (state_q == S_MEMWRITE);
    // Timeout fires on the last allowed wait cycle. It needs mem_ready low,
    // so a completion arriving in that same cycle still wins.
    assign timeout    = (WAIT_LIMIT != 0) && wait_state && !mem_ready &&
                        (wait_cnt == LIMIT_M1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_FETCH;
            fault_q  <= 2'b00;
            wait_cnt <= 8'd0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            if (state_d != state_q)
                wait_cnt <= 8'd0;
            else if (wait_state && !mem_ready)
                wait_cnt <= wait_cnt + 8'd1;
        end
    end

    always_comb begin
        state_d      = state_q;
        fault_d      = fault_q;
        aluop        = 2'b00;
        funct7_valid = 1'b0;
        adrsrc       = 1'b0;
        resultsrc    = 2'b00;
        alusrca      = 2'b00;
        alusrcb      = 2'b00;
        pcupdate     = 1'b0;
        branch       = 1'b0;
        irwrite_raw  = 1'b0;
        memwrite_raw = 1'b0;
        regwrite_raw = 1'b0;

        case (state_q)
            S_FETCH: begin
                alusrcb     = 2'b10;
                resultsrc   = 2'b10;
                irwrite_raw = mem_ready;
                pcupdate    = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                // ALU computes the branch/jump target from OldPC + imm.
                alusrca = 2'b01;
                alusrcb = 2'b01;
                case (op)
                    7'b0000011,
                    7'b0100011: state_d = S_MEMADR;
                    7'b0110011: state_d = S_EXECUTER;
                    7'b0010011: state_d = S_EXECUTEI;
                    7'b1101111: state_d = S_JAL;
                    7'b1100011: state_d = S_BEQ;
                    default: begin
                        state_d = S_FAULT;
                        fault_d = 2'b01;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                state_d = (op == 7'b0000011) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adrsrc = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                resultsrc    = 2'b01;
                regwrite_raw = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWRITE: begin
                // The strobe stays high through the wait cycles.
                adrsrc       = 1'b1;
                memwrite_raw = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECUTER: begin
                alusrca      = 2'b10;
                aluop        = 2'b10;
                funct7_valid = 1'b1;
                state_d      = S_ALUWB;
            end
            S_EXECUTEI: begin
                alusrca      = 2'b10;
                alusrcb      = 2'b01;
                aluop        = 2'b10;
                // Only shifts-right carry a meaningful funct7 in I-type.
                // This keeps addi from decoding as sub.
                funct7_valid = (funct3 == 3'b101);
                state_d      = S_ALUWB;
            end
            S_ALUWB: begin
                regwrite_raw = 1'b1;
                state_d      = S_FETCH;
            end
            S_JAL: begin
                alusrca  = 2'b01;
                alusrcb  = 2'b10;
                pcupdate = 1'b1;
                state_d  = S_ALUWB;
            end
            S_BEQ: begin
                alusrca = 2'b10;
                aluop   = 2'b01;
                branch  = 1'b1;
                state_d = S_FETCH;
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_FAULT;
                fault_d = 2'b01;
            end
        endcase

        if (timeout) begin
            state_d = S_FAULT;
            fault_d = 2'b10;
        end
    end

    // Enables drop combinationally with rst, so nothing commits while it is held.
    assign pcwrite  = !rst && (pcupdate || (branch && zero));
    assign irwrite  = !rst && irwrite_raw;
    assign memwrite = !rst && memwrite_raw;
    assign regwrite = !rst && regwrite_raw;
    assign state    = state_q;
    assign fault    = fault_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm. For each instruction, a reference model
// builds the expected per-cycle trace from the instruction-level rules: which
// phases the opcode visits, and how many memory wait cycles occur before a
// timeout. The bench drives mem_ready from that trace and checks every cycle.
module tb_multicycle_control_fsm;

    localparam int WL = 4;
    localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3,
        MEMWB = 4'd4, MEMWRITE = 4'd5, EXECR = 4'd6, ALUWB = 4'd7, EXECI = 4'd8,
        JAL = 4'd9, BEQ = 4'd10, FAULTS = 4'd11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic [1:0] aluop, resultsrc, alusrca, alusrcb, fault;
    logic       funct7_valid, pcwrite, irwrite, memwrite, regwrite, adrsrc;
    logic [3:0] state;

    multicycle_control_fsm #(.WAIT_LIMIT(WL)) dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .zero(zero),
        .mem_ready(mem_ready), .aluop(aluop), .funct7_valid(funct7_valid),
        .pcwrite(pcwrite), .irwrite(irwrite), .memwrite(memwrite),
        .regwrite(regwrite), .adrsrc(adrsrc), .resultsrc(resultsrc),
        .alusrca(alusrca), .alusrcb(alusrcb), .state(state), .fault(fault)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [3:0] st;
        logic       mr;
        logic [1:0] aluop;
        logic       f7;
        logic       pcw;
        logic       irw;
        logic       memw;
        logic       regw;
        logic       adr;
        logic [1:0] rsrc;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic [1:0] flt;
    } step_t;

    step_t exp_q[$];

    // mem_ready is irrelevant outside wait states, so it is randomised there.
    function automatic step_t blank(input logic [3:0] st);
        step_t s;
        s    = '0;
        s.st = st;
        s.mr = 1'($urandom_range(0, 1));
        return s;
    endfunction

    // Memory-facing phase: n wait cycles, then a completing cycle, unless the
    // wait reaches WL cycles first.
    task automatic push_wait(input logic [3:0] st, input int n, output bit timed_out);
        step_t s;
        timed_out = 1'b0;
        for (int i = 0; i <= n; i++) begin
            s    = blank(st);
            s.mr = (i == n);
            if (st == FETCH) begin
                s.srcb = 2'b10;
                s.rsrc = 2'b10;
                s.irw  = s.mr;
                s.pcw  = s.mr;
            end else begin
                s.adr  = 1'b1;
                s.memw = (st == MEMWRITE);
            end
            exp_q.push_back(s);
            if (i < n && WL != 0 && i == WL - 1) begin
                timed_out = 1'b1;
                break;
            end
        end
    endtask

    task automatic push_fault(input logic [1:0] code, input int len);
        step_t s;
        for (int i = 0; i < len; i++) begin
            s     = blank(FAULTS);
            s.flt = code;
            exp_q.push_back(s);
        end
    endtask

    task automatic push_aluwb();
        step_t s;
        s      = blank(ALUWB);
        s.regw = 1'b1;
        exp_q.push_back(s);
    endtask

    task automatic build(input logic [6:0] o, input logic [2:0] f3, input logic z,
                         input int fw, input int mw, input int flen, output bit faulted);
        step_t s;
        bit    to;
        exp_q.delete();
        faulted = 1'b0;
        push_wait(FETCH, fw, to);
        if (to) begin
            push_fault(2'b10, flen);
            faulted = 1'b1;
            return;
        end
        s = blank(DECODE); s.srca = 2'b01; s.srcb = 2'b01; exp_q.push_back(s);
        case (o)
            7'b0000011, 7'b0100011: begin
                s = blank(MEMADR); s.srca = 2'b10; s.srcb = 2'b01; exp_q.push_back(s);
                push_wait((o == 7'b0000011) ? MEMREAD : MEMWRITE, mw, to);
                if (to) begin
                    push_fault(2'b10, flen);
                    faulted = 1'b1;
                end else if (o == 7'b0000011) begin
                    s = blank(MEMWB); s.rsrc = 2'b01; s.regw = 1'b1; exp_q.push_back(s);
                end
            end
            7'b0110011: begin
                s = blank(EXECR); s.srca = 2'b10; s.aluop = 2'b10; s.f7 = 1'b1;
                exp_q.push_back(s);
                push_aluwb();
            end
            7'b0010011: begin
                s = blank(EXECI); s.srca = 2'b10; s.srcb = 2'b01; s.aluop = 2'b10;
                s.f7 = (f3 == 3'b101);
                exp_q.push_back(s);
                push_aluwb();
            end
            7'b1101111: begin
                s = blank(JAL); s.srca = 2'b01; s.srcb = 2'b10; s.pcw = 1'b1;
                exp_q.push_back(s);
                push_aluwb();
            end
            7'b1100011: begin
                s = blank(BEQ); s.srca = 2'b10; s.aluop = 2'b01; s.pcw = z;
                exp_q.push_back(s);
            end
            default: begin
                push_fault(2'b01, flen);
                faulted = 1'b1;
            end
        endcase
    endtask

    // Replays exp_q one cycle per step. The bench starts and ends at a negedge.
    task automatic run_trace(input string name, input logic [6:0] o, input logic [2:0] f3,
                             input logic z);
        step_t s;
        logic [15:0] got, want;
        op = o; funct3 = f3; zero = z;
        for (int i = 0; i < exp_q.size(); i++) begin
            s = exp_q[i];
            mem_ready = s.mr;
            #1;
            n_cmp++;
            if (state !== s.st) begin
                n_bad++;
                $display("FAIL %s step %0d state: got %0d want %0d", name, i, state, s.st);
            end
            got  = {aluop, funct7_valid, pcwrite, irwrite, memwrite, regwrite, adrsrc,
                    resultsrc, alusrca, alusrcb, fault};
            want = {s.aluop, s.f7, s.pcw, s.irw, s.memw, s.regw, s.adr,
                    s.rsrc, s.srca, s.srcb, s.flt};
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL %s step %0d (state %0d) outputs: got %h want %h",
                         name, i, s.st, got, want);
            end
            @(negedge clk);
        end
    endtask

    task automatic do_reset(input string name);
        rst = 1'b1;
        mem_ready = 1'b1;
        #1;
        n_cmp++;
        if (state !== FETCH || fault !== 2'b00) begin
            n_bad++;
            $display("FAIL %s reset state/fault: got %0d/%0d want 0/0", name, state, fault);
        end
        n_cmp++;
        if ({pcwrite, irwrite, memwrite, regwrite} !== 4'b0000 || alusrcb !== 2'b10 ||
            resultsrc !== 2'b10 || {aluop, funct7_valid, adrsrc, alusrca} !== 6'd0) begin
            n_bad++;
            $display("FAIL %s reset outputs: got en=%b srcb=%b rsrc=%b want en=0000 srcb=10 rsrc=10",
                     name, {pcwrite, irwrite, memwrite, regwrite}, alusrcb, resultsrc);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_instr(input string name, input logic [6:0] o, input logic [2:0] f3,
                             input logic z, input int fw, input int mw, input int flen);
        bit faulted;
        build(o, f3, z, fw, mw, flen, faulted);
        run_trace(name, o, f3, z);
        if (faulted) do_reset({name, "_rst"});
    endtask

    task automatic test_reset();
        do_reset("reset");
    endtask

    task automatic test_alu();
        run_instr("add", 7'b0110011, 3'b000, 1'b0, 0, 0, 3);
        run_instr("addi", 7'b0010011, 3'b000, 1'b0, 0, 0, 3);
        run_instr("srai", 7'b0010011, 3'b101, 1'b0, 0, 0, 3);
        run_instr("jal", 7'b1101111, 3'b000, 1'b0, 1, 0, 3);
    endtask

    task automatic test_load_wait();
        run_instr("lw_wait3", 7'b0000011, 3'b010, 1'b0, 0, 3, 3);
    endtask

    task automatic test_beq();
        run_instr("beq_z1", 7'b1100011, 3'b000, 1'b1, 0, 0, 3);
        run_instr("beq_z0", 7'b1100011, 3'b000, 1'b0, 0, 0, 3);
    endtask

    task automatic test_illegal();
        run_instr("illegal", 7'b1111111, 3'b000, 1'b0, 0, 0, 20);
    endtask

    task automatic test_timeout();
        run_instr("sw_timeout", 7'b0100011, 3'b010, 1'b0, 0, 6, 3);
        run_instr("sw_late_ready", 7'b0100011, 3'b010, 1'b0, 0, WL - 1, 3);
        run_instr("fetch_timeout", 7'b0110011, 3'b000, 1'b0, WL, 0, 3);
        run_instr("fetch_late_ready", 7'b0110011, 3'b000, 1'b0, WL - 1, 0, 3);
    endtask

    // Reset asserted mid-cycle must kill an in-flight memwrite/regwrite at once.
    task automatic test_reset_mid();
        logic [6:0] ops[2];
        logic [3:0] sts[2];
        ops[0] = 7'b0100011; sts[0] = MEMWRITE;
        ops[1] = 7'b0110011; sts[1] = ALUWB;
        for (int k = 0; k < 2; k++) begin
            op = ops[k];
            mem_ready = 1'b1;
            repeat (3) @(negedge clk);
            mem_ready = 1'b0;
            #1;
            n_cmp++;
            if (state !== sts[k] || (memwrite | regwrite) !== 1'b1) begin
                n_bad++;
                $display("FAIL reset_mid%0d pre: got state %0d wr %b want state %0d wr 1",
                         k, state, memwrite | regwrite, sts[k]);
            end
            #2 rst = 1'b1;
            #1;
            n_cmp++;
            if (state !== FETCH || {memwrite, regwrite} !== 2'b00) begin
                n_bad++;
                $display("FAIL reset_mid%0d post: got state %0d mw/rw %b want 0 00",
                         k, state, {memwrite, regwrite});
            end
            @(negedge clk);
            rst = 1'b0;
        end
    endtask

    task automatic test_random();
        logic [6:0] legal[6];
        logic [6:0] o;
        int idx, fw, mw;
        legal[0] = 7'b0000011; legal[1] = 7'b0100011; legal[2] = 7'b0110011;
        legal[3] = 7'b0010011; legal[4] = 7'b1101111; legal[5] = 7'b1100011;
        for (int n = 0; n < 60; n++) begin
            idx = $urandom_range(0, 6);
            if (idx < 6) begin
                o = legal[idx];
            end else begin
                o = 7'($urandom_range(0, 127));
                for (int j = 0; j < 6; j++)
                    if (o == legal[j]) o = 7'b1111111;
            end
            fw = ($urandom_range(0, 7) == 0) ? $urandom_range(WL, WL + 2) : $urandom_range(0, 2);
            mw = ($urandom_range(0, 5) == 0) ? $urandom_range(WL - 1, WL + 2) : $urandom_range(0, 2);
            run_instr($sformatf("rand%0d", n), o, 3'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)), fw, mw, $urandom_range(1, 4));
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_alu();
        test_load_wait();
        test_beq();
        test_illegal();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Main controller for the multicycle RV32I core. Sits directly upstream of alu_control.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives aluop into alu_control, plus all datapath enables and mux selects.
- Stalls on memory wait states and traps on illegal opcodes or memory timeouts.

Parameters:
WAIT_LIMIT, 16, max consecutive cycles a memory state waits for mem_ready before fault; 0 disables timeout (range 0..255)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
op  input  7  instruction opcode, valid from DECODE onward (instr[6:0] from IR)
funct3  input  3  instr[14:12]
zero  input  1  ALU zero flag
mem_ready  input  1  memory completes current access this cycle
aluop  output  2  to alu_control: 00 add, 01 sub/compare, 10 funct-decoded
funct7_valid  output  1  datapath gates the funct7 input of alu_control with this
pcwrite  output  1  PC register enable
irwrite  output  1  instruction/old-PC register enable
memwrite  output  1  memory write strobe
regwrite  output  1  register file write enable
adrsrc  output  1  0 = PC, 1 = ALU result as memory address
resultsrc  output  2  00 ALUOut, 01 Data, 10 ALUResult
alusrca  output  2  00 PC, 01 OldPC, 10 rs1
alusrcb  output  2  00 rs2, 01 imm, 10 constant 4
state  output  4  current state encoding, for debug
fault  output  2  00 none, 01 illegal opcode, 10 memory timeout

Behaviour:
- Reset:
  - Async on rst high: state = FETCH (0), wait counter = 0, fault = 00.
  - While rst is high, pcwrite, irwrite, memwrite and regwrite are forced to 0.
  - Other outputs take their FETCH values: alusrcb = 10, resultsrc = 10, rest 0.
- Output style: Moore, decoded from state. Exceptions: irwrite and pcwrite also use mem_ready and zero. Unlisted outputs are 0 in every state.
- FETCH (0):
  - adrsrc = 0, alusrca = 00, alusrcb = 10, aluop = 00, resultsrc = 10.
  - irwrite = pcupdate = mem_ready.
  - Go to DECODE when mem_ready, else stay.
- DECODE (1):
  - alusrca = 01, alusrcb = 01, aluop = 00 (branch/jump target).
  - Next state by op: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1101111 -> JAL; 1100011 -> BEQ; any other -> FAULT with fault = 01.
- MEMADR (2):
  - alusrca = 10, alusrcb = 01, aluop = 00.
  - Go to MEMREAD if op = 0000011, else MEMWRITE.
- MEMREAD (3): adrsrc = 1, resultsrc = 00. Go to MEMWB when mem_ready, else stay.
- MEMWB (4): resultsrc = 01, regwrite = 1. Go to FETCH.
- MEMWRITE (5):
  - adrsrc = 1, resultsrc = 00, memwrite = 1.
  - memwrite holds high across wait cycles. Go to FETCH when mem_ready.
- EXECUTER (6): alusrca = 10, alusrcb = 00, aluop = 10, funct7_valid = 1. Go to ALUWB.
- EXECUTEI (8):
  - alusrca = 10, alusrcb = 01, aluop = 10.
  - funct7_valid = 1 only when funct3 = 101 (srai/srli); 0 otherwise, so addi never decodes as sub.
  - Go to ALUWB.
- ALUWB (7): resultsrc = 00, regwrite = 1. Go to FETCH.
- JAL (9): alusrca = 01, alusrcb = 10, aluop = 00, resultsrc = 00, pcupdate = 1. Go to ALUWB.
- BEQ (10): alusrca = 10, alusrcb = 00, aluop = 01, resultsrc = 00, branch = 1. Go to FETCH.
- PC enable: pcwrite = pcupdate | (branch & zero).
- FAULT (11):
  - All enables 0. Sticky until rst; fault holds its code.
  - fault is registered, set on the transition into FAULT.
- Wait counter (8-bit):
  - Increments each cycle spent in FETCH, MEMREAD or MEMWRITE with mem_ready = 0.
  - Clears on any state change.
  - If WAIT_LIMIT != 0 and counter = WAIT_LIMIT-1 with mem_ready still 0, next state = FAULT with fault = 10.
  - If mem_ready arrives in that same cycle, it wins: normal transition, no fault.
- Encodings 12..15 are unreachable; if entered, next state = FAULT, fault = 01.
- Reset mid-instruction: in-flight memwrite/regwrite drop combinationally with rst; no partial commit beyond the current cycle.

Test Plan:
- add (op = 0110011), mem_ready tied 1 -> states 0,1,6,7,0; aluop = 10 in state 6; funct7_valid = 1; regwrite = 1 for exactly one cycle in state 7; total 4 cycles.
- lw with mem_ready low for 3 cycles in MEMREAD -> state 3 held 4 cycles; then MEMWB with resultsrc = 01, regwrite = 1; adrsrc = 1 throughout the wait.
- beq with zero = 1 then zero = 0 -> pcwrite = 1 in state 10 only when zero = 1; aluop = 01 in both cases.
- addi (op = 0010011, funct3 = 000) -> funct7_valid = 0; srai (funct3 = 101) -> funct7_valid = 1; aluop = 10 in both.
- op = 1111111 -> FAULT (state = 11), fault = 01, all enables 0 for 20 cycles; rst pulse -> state = 0, fault = 00.
- WAIT_LIMIT = 4, sw with mem_ready held 0 -> memwrite high for 4 cycles, then state = 11, fault = 10; repeat with mem_ready rising on the 4th wait cycle -> state 0, no fault.
